// File: rtl/graphite_cmd_fifo.sv
// -----------------------------------------------------------------------------
// graphite_cmd_fifo
//
// Purpose:
//   This block buffers 32-bit Graphite command words between the CPU and the
//   rasterizer. The CPU writes commands through a small register port, and the
//   block presents them on an AXI-stream master.
//
//   The queue has two parts:
//     - a circular RAM of DEPTH-1 words;
//     - a single output register that drives tdata/tvalid.
//   Together they hold up to DEPTH words.
//
//   Software can read the following state through STATUS:
//     - level;
//     - full;
//     - empty;
//     - a sticky overflow flag.
//
// Ports:
//   clk                pixel/system clock; all logic on its rising edge
//   reset_n_i          synchronous active-low reset
//   sel_i              bus request, held until ack_o
//   wr_i               1 = write, 0 = read (valid while sel_i)
//   addr_i             register index: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved
//   data_in_i          bus write data
//   data_out_o         bus read data, valid in the ack_o cycle
//   ack_o              one-cycle completion strobe
//   cmd_axis_tvalid_o  command word valid
//   cmd_axis_tready_i  rasterizer ready
//   cmd_axis_tdata_o   command word
//   empty_o            no words held
//   full_o             level equals DEPTH
//   level_o            words held (RAM plus output stage)
// -----------------------------------------------------------------------------
module graphite_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n_i,
  input  logic          sel_i,
  input  logic          wr_i,
  input  logic [1:0]    addr_i,
  input  logic [31:0]   data_in_i,
  output logic [31:0]   data_out_o,
  output logic          ack_o,
  output logic          cmd_axis_tvalid_o,
  input  logic          cmd_axis_tready_i,
  output logic [31:0]   cmd_axis_tdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [LW-1:0] level_o
);

  localparam int RAM_WORDS = DEPTH - 1;
  // Pointer/count width: RAM_WORDS is at most DEPTH-1, which fits in clog2(DEPTH) bits.
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RAM_WORDS - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  // Pointers wrap modulo DEPTH-1. DEPTH-1 is not a power of two, so the wrap
  // uses an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   ram_q [RAM_WORDS];
  logic          ack_q;
  logic [31:0]   data_out_q,  data_out_d;
  logic          tvalid_q,    tvalid_d;
  logic [31:0]   tdata_q;
  logic [LW-1:0] level_q,     level_d;
  logic          empty_q,     empty_d;
  logic          full_q,      full_d;
  logic          overflow_q,  overflow_d;
  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [PW-1:0] ram_cnt_q,   ram_cnt_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic accept, bus_wr, bus_rd, data_wr, ctrl_wr;
  logic push, drop, flush, ovf_clr, pop, refill;
  logic [31:0] status_word;

  // A request is not re-accepted in its own ack cycle. This gives the one-idle-cycle gap.
  assign accept  = sel_i & ~ack_q;
  assign bus_wr  = accept & wr_i;
  assign bus_rd  = accept & ~wr_i;
  assign data_wr = bus_wr & (addr_i == ADDR_DATA);
  assign ctrl_wr = bus_wr & (addr_i == ADDR_CONTROL);
  assign push    = data_wr & ~full_q;
  assign drop    = data_wr & full_q;
  assign flush   = ctrl_wr & data_in_i[0];
  assign ovf_clr = ctrl_wr & data_in_i[1];
  assign pop     = tvalid_q & cmd_axis_tready_i;
  // The output stage takes the RAM head when the stage is idle or being
  // emptied this edge.
  assign refill  = (~tvalid_q | pop) & (ram_cnt_q != '0);

  assign status_word = {16'h0000, 8'(level_q), 5'b00000, overflow_q, full_q, empty_q};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out_d = '0;
    if (bus_rd && addr_i == ADDR_STATUS) begin
      data_out_d = status_word;
    end

    level_d   = level_q;
    ram_cnt_d = ram_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tvalid_d  = tvalid_q;

    if (flush) begin
      level_d   = '0;
      ram_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      tvalid_d  = 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      case ({push, refill})
        2'b10:   ram_cnt_d = ram_cnt_q + PW'(1);
        2'b01:   ram_cnt_d = ram_cnt_q - PW'(1);
        default: ram_cnt_d = ram_cnt_q;
      endcase
      if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
      if (refill) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (refill)   tvalid_d = 1'b1;
      else if (pop) tvalid_d = 1'b0;
    end

    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(DEPTH));

    // A drop takes priority over a simultaneous clear.
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Storage RAM. This block has no reset so that it maps onto block RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      ram_q[wr_ptr_q] <= data_in_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers and output stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      ack_q      <= 1'b0;
      data_out_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
    end else begin
      ack_q      <= accept;
      data_out_q <= data_out_d;
      tvalid_q   <= tvalid_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      // The RAM is read with a registered read straight into the output
      // stage. tdata is otherwise held until the word is popped.
      if (flush)       tdata_q <= '0;
      else if (refill) tdata_q <= ram_q[rd_ptr_q];
    end
  end

  assign ack_o             = ack_q;
  assign data_out_o        = data_out_q;
  assign cmd_axis_tvalid_o = tvalid_q;
  assign cmd_axis_tdata_o  = tdata_q;
  assign empty_o           = empty_q;
  assign full_o            = full_q;
  assign level_o           = level_q;

endmodule

// File: doc/graphite_cmd_fifo.md
# graphite_cmd_fifo

Bus-to-stream command buffer sitting directly upstream of the Graphite rasterizer's command input inside the video subsystem. The CPU writes 32-bit Graphite command words through a simple memory-mapped register port. The block queues them in a DEPTH-entry FIFO and presents them on the 32-bit AXI-stream command master consumed by the rasterizer. Status and control registers expose FIFO level, full, empty and a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 16, FIFO capacity in words including the output stage; power of two, at least 4.
- LW, $clog2(DEPTH)+1, width of level_o (derived; do not override).

Ports:
- clk  in  1  pixel/system clock; all logic on its rising edge.
- reset_n_i  in  1  reset, synchronous and active-low.
- sel_i  in  1  bus request; held by the master until ack_o.
- wr_i  in  1  1 = write, 0 = read; valid while sel_i.
- addr_i  in  2  register word index: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
- data_in_i  in  32  write data.
- data_out_o  out  32  read data; valid in the ack_o cycle.
- ack_o  out  1  one-cycle completion strobe.
- cmd_axis_tvalid_o  out  1  command word valid.
- cmd_axis_tready_i  in  1  rasterizer ready.
- cmd_axis_tdata_o  out  32  command word.
- empty_o  out  1  no words held.
- full_o  out  1  level equals DEPTH.
- level_o  out  LW  words held (storage plus output stage).

## Operation
- Bus accept: a request is accepted on an edge where sel_i=1 and ack_o=0. ack_o is 1 for exactly the following cycle, then 0. This enforces one idle ack-free cycle between back-to-back accepts.
- DATA write:
  - If not full, push data_in_i.
  - If full, drop the word and set the sticky overflow flag. Still ack; never stall.
- DATA read returns 0.
- STATUS read: bit0 empty, bit1 full, bit2 overflow, bits[15:8] level (zero-extended), all other bits 0.
- CONTROL write:
  - bit0=1 flushes: pointers, level and output stage are cleared, and tvalid drops next cycle.
  - bit1=1 clears overflow.
  - Both may be set in one write.
  - Reads of CONTROL and reserved return 0. Writes to reserved are acked and ignored.
- Storage: circular RAM of DEPTH-1 words with rd/wr pointers wrapping modulo DEPTH-1 via explicit compare. Backs a single output register that drives tdata/tvalid.
  - Output register refills from RAM head whenever it is empty, or is being popped, and RAM is non-empty.
  - A push into an empty FIFO (RAM empty, output stage empty or popping) goes to RAM and reaches the output on the next edge.
- Pop: an edge with tvalid_o=1 and tready_i=1.
- Level update per edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together.
  - Forced to 0 on flush. Flush beats a concurrent pop.
- AXI rule: once tvalid_o=1, tdata_o holds until the pop edge. Flush is the only permitted exception; software flushes only with the rasterizer idle.
- Overflow is set by a dropped write and cleared only by CONTROL bit1 or reset. Set wins if a drop and a clear were simultaneous (impossible on the single bus, but coded so).

## Timing
- Reset (reset_n_i=0 at an edge) values: ack_o 0, data_out_o 0, cmd_axis_tvalid_o 0, cmd_axis_tdata_o 0, empty_o 1, full_o 0, level_o 0, overflow 0.
- A reset mid-transaction discards any pending ack and all queued words.
- All outputs are registered.
- Write-to-stream latency into an empty FIFO:
  - Accept edge E0 writes RAM.
  - Edge E1 loads the output register.
  - tvalid_o is high after E1.
- level_o, full_o and empty_o update at the accept/pop edge (E0), ahead of tvalid.
- Sustained throughput: one word per cycle on the stream side. Bus side is at most one write per two cycles.
- With tready_i held 1, each word is popped on the edge after it becomes valid, and tvalid_o stays 1 while words remain.
- STATUS read reflects state sampled at the accept edge.

## Test plan
- Reset then idle:
  - Expect tvalid_o=0, empty_o=1, level_o=0.
  - A STATUS read returns 0x00000001 with ack_o high for exactly one cycle.
- Write 0xA5A50001 to DATA with tready_i=1:
  - tvalid_o rises two cycles after sel_i is first sampled, with tdata_o=0xA5A50001.
  - It pops on the next edge and level returns to 0.
- tready_i=0; write DEPTH+2 words 1..DEPTH+2:
  - full_o=1 and level_o=DEPTH.
  - STATUS bit2=1, bits[15:8]=DEPTH.
  - Then tready_i=1: exactly words 1..DEPTH emerge in order, with tdata stable while stalled.
- Toggle tready_i randomly while writing 100 sequential words:
  - The output sequence is exact, with no loss or duplication across pointer wrap.
  - level_o always equals writes minus pops.
- With 5 words queued and tvalid_o=1, write CONTROL=0x3:
  - tvalid_o=0 and level_o=0 next cycle, and overflow is cleared.
  - A subsequent write streams normally.
- Assert reset_n_i=0 for one edge with 3 words queued and a request pending:
  - All outputs return to their reset values and no ack is issued.
